store_buffer: RTL

Post-commit store buffer and load port that sits directly upstream of the data memory. It owns that memory's single port, which reads combinationally and writes on the clock edge. Committed stores are queued and drained in program order whenever the port is idle. Loads from the pipeline take the port, receive store-to-load forwarding on exact matches, stall on partial overlaps, and return a size-masked, sign- or zero-extended result one cycle after acceptance.

---
 rtl/store_buffer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// Post-commit store buffer that owns the data-memory port: queues committed stores,
// drains them in order when the port is free, and serves loads with exact-match forwarding.
module store_buffer #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [63:0]      ld_addr,
    input  logic [3:0]       ld_size,
    input  logic             ld_signed,
    input  logic [TAG_W-1:0] ld_tag,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [63:0]      st_addr,
    input  logic [3:0]       st_size,
    input  logic [63:0]      st_data,
    output logic             resp_valid,
    output logic [TAG_W-1:0] resp_tag,
    output logic [63:0]      resp_data,
    output logic             empty,
    output logic [63:0]      mem_address,
    output logic             mem_write_enable,
    output logic             mem_read_enable,
    output logic [63:0]      mem_write_data,
    output logic [3:0]       mem_xfer_size,
    input  logic [63:0]      mem_read_data
);

    localparam int PTR_W = $clog2(DEPTH);

    function automatic logic [3:0] norm_size(input logic [3:0] s);
        case (s)
            4'd1, 4'd2, 4'd4: norm_size = s;
            default:          norm_size = 4'd8;
        endcase
    endfunction

    function automatic logic [63:0] align(input logic [63:0] a, input logic [3:0] s);
        align = a & ~({60'd0, s} - 64'd1);
    endfunction

    function automatic logic [63:0] extend(input logic [63:0] raw, input logic [3:0] s,
                                           input logic sg);
        case (s)
            4'd1:    extend = {{56{sg & raw[7]}}, raw[7:0]};
            4'd2:    extend = {{48{sg & raw[15]}}, raw[15:0]};
            4'd4:    extend = {{32{sg & raw[31]}}, raw[31:0]};
            default: extend = raw;
        endcase
    endfunction

    logic [63:0]    ent_addr [DEPTH];
    logic [3:0]     ent_size [DEPTH];
    logic [63:0]    ent_data [DEPTH];
    logic [PTR_W-1:0] head, tail, idx;
    logic [PTR_W:0] count;

    logic [3:0]  ld_size_n, st_size_n;
    logic [63:0] ld_base, st_base, fwd_data, raw_data;
    logic [64:0] ld_end, ent_end;
    logic        hit, fwd, full, do_drain, do_read, ld_accept, st_accept;

    assign ld_size_n = norm_size(ld_size);
    assign st_size_n = norm_size(st_size);
    assign ld_base   = align(ld_addr, ld_size_n);
    assign st_base   = align(st_addr, st_size_n);
    assign ld_end    = {1'b0, ld_base} + {61'd0, ld_size_n};
    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign empty     = (count == '0);

    // Oldest-to-youngest scan, so the last overlapping entry decides forwarding.
    always_comb begin
        hit      = 1'b0;
        fwd      = 1'b0;
        fwd_data = '0;
        idx      = head;
        ent_end  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx     = head + PTR_W'(k);
            ent_end = {1'b0, ent_addr[idx]} + {61'd0, ent_size[idx]};
            if (((PTR_W+1)'(k) < count) && ({1'b0, ent_addr[idx]} < ld_end) &&
                ({1'b0, ld_base} < ent_end)) begin
                hit      = 1'b1;
                fwd      = (ent_addr[idx] == ld_base) && (ent_size[idx] == ld_size_n);
                fwd_data = ent_data[idx];
            end
        end
    end

    // Handshakes: a transfer happens on a rising edge where valid && ready; ready never
    // depends on valid, and a requester holds its payload stable until it is taken.
    always_comb begin
        do_drain = 1'b0;
        do_read  = 1'b0;
        ld_ready = 1'b0;
        if (!reset) begin
            if (full) begin
                do_drain = 1'b1;
            end else if (!hit) begin
                ld_ready = 1'b1;
                if (ld_valid)        do_read  = 1'b1;
                else if (!empty)     do_drain = 1'b1;
            end else begin
                do_drain = 1'b1;
                ld_ready = fwd;
            end
        end
    end

    assign st_ready  = !reset && !full;
    assign ld_accept = ld_valid && ld_ready;
    assign st_accept = st_valid && st_ready;
    assign raw_data  = fwd ? fwd_data : mem_read_data;

    always_comb begin
        mem_address      = '0;
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;
        mem_write_data   = '0;
        mem_xfer_size    = 4'd8;
        if (do_drain) begin
            mem_address      = ent_addr[head];
            mem_write_enable = 1'b1;
            mem_write_data   = ent_data[head];
            mem_xfer_size    = ent_size[head];
        end else if (do_read) begin
            mem_address     = ld_base;
            mem_read_enable = 1'b1;
            mem_xfer_size   = ld_size_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            resp_valid <= 1'b0;
            resp_tag   <= '0;
            resp_data  <= '0;
        end else begin
            if (st_accept) tail <= tail + 1'b1;
            if (do_drain)  head <= head + 1'b1;
            count      <= count + (PTR_W+1)'(st_accept) - (PTR_W+1)'(do_drain);
            resp_valid <= ld_accept;
            if (ld_accept) begin
                resp_tag  <= ld_tag;
                resp_data <= extend(raw_data, ld_size_n, ld_signed);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (st_accept) begin
            ent_addr[tail] <= st_base;
            ent_size[tail] <= st_size_n;
            ent_data[tail] <= st_data;
        end
    end

endmodule
